// File: rtl/frame_tx_packer.sv
// frame_tx_packer: packs a length-bounded 32-bit word stream into 16-bit host transfers with sof/eof.
// Define FRAME_TX_CHECKSUM_EN to append a 32-bit additive checksum trailer to each frame.
module frame_tx_packer #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sync,
  input  logic [LEN_W-1:0] i_header_size,
  input  logic [LEN_W-1:0] i_payload_len,
  input  logic [31:0]      i_in_data,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  output logic [15:0]      o_tx_data,
  output logic             o_tx_vld,
  input  logic             i_tx_rdy,
  output logic             o_tx_sof,
  output logic             o_tx_eof,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_overrun
);
`ifdef FRAME_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, LO, HI, CK_LO, CK_HI} state_t;
  localparam state_t FIN = CK_LO;
  logic [31:0] csum;
`else
  typedef enum logic [1:0] {IDLE, LOAD, LO, HI} state_t;
  localparam state_t FIN = IDLE;
`endif
  state_t state, state_nx;
  logic [31:0] word;
  logic [LEN_W:0] words_left, total;
  logic first, last, in_hs, tx_hs, eof_hs;

  assign total  = {1'b0, i_header_size} + {1'b0, i_payload_len};
  assign last   = words_left == '0;
  assign in_hs  = i_in_vld && o_in_rdy;
  assign tx_hs  = o_tx_vld && i_tx_rdy;
  assign eof_hs = tx_hs && o_tx_eof;

  always_comb begin
    o_in_rdy = state == LOAD || (state == HI && i_tx_rdy && !last);
    o_tx_vld = state != IDLE && state != LOAD;
    o_busy   = state != IDLE;
    o_tx_sof = state == LO && first;
`ifdef FRAME_TX_CHECKSUM_EN
    o_tx_data = state == LO ? word[15:0] : state == HI ? word[31:16] :
                state == CK_LO ? csum[15:0] : state == CK_HI ? csum[31:16] : '0;
    o_tx_eof  = state == CK_HI;
`else
    o_tx_data = state == LO ? word[15:0] : state == HI ? word[31:16] : '0;
    o_tx_eof  = state == HI && last;
`endif
  end

  // i_sync overrides whatever frame is in flight
  always_comb begin
    state_nx = state;
    if (i_sync) state_nx = total != '0 ? LOAD : IDLE;
    else
      case (state)
        LOAD:    state_nx = in_hs ? LO : LOAD;
        LO:      state_nx = tx_hs ? HI : LO;
        HI:      state_nx = !tx_hs ? HI : in_hs ? LO : !last ? LOAD : FIN;
`ifdef FRAME_TX_CHECKSUM_EN
        CK_LO:   state_nx = tx_hs ? CK_HI : CK_LO;
        CK_HI:   state_nx = tx_hs ? IDLE : CK_HI;
`endif
        default: state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      word        <= '0;
      words_left  <= '0;
      first       <= 1'b0;
      o_frame_cnt <= '0;
      o_overrun   <= 1'b0;
`ifdef FRAME_TX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state     <= state_nx;
      o_overrun <= i_sync && o_busy && !eof_hs;
      if (eof_hs) o_frame_cnt <= o_frame_cnt + 1'b1;
      if (i_sync) begin
        words_left <= total;
        first      <= 1'b1;
`ifdef FRAME_TX_CHECKSUM_EN
        csum       <= '0;
`endif
      end else begin
        if (in_hs) begin
          word       <= i_in_data;
          words_left <= words_left - 1'b1;
`ifdef FRAME_TX_CHECKSUM_EN
          csum       <= csum + i_in_data;
`endif
        end
        if (state == LO && tx_hs) first <= 1'b0;
      end
    end
endmodule

// File: tb/tb_frame_tx_packer.sv
// tb_frame_tx_packer: randomized scoreboard bench for frame_tx_packer against a frame-level reference model.
module tb_frame_tx_packer;
  typedef struct packed {logic [15:0] d; logic sof; logic eof;} hw_t;

  logic clk = 1'b0, rst_n = 1'b0, i_sync = 1'b0, i_in_vld = 1'b0, i_tx_rdy = 1'b0;
  logic [15:0] i_header_size = '0, i_payload_len = '0;
  logic [31:0] i_in_data = '0;
  logic o_in_rdy, o_tx_vld, o_tx_sof, o_tx_eof, o_busy, o_overrun;
  logic [15:0] o_tx_data;
  logic [2:0] o_frame_cnt;

  frame_tx_packer #(.LEN_W(16), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_header_size(i_header_size),
    .i_payload_len(i_payload_len), .i_in_data(i_in_data), .i_in_vld(i_in_vld),
    .o_in_rdy(o_in_rdy), .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy),
    .o_tx_sof(o_tx_sof), .o_tx_eof(o_tx_eof), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, accepted = 0, n_pop = 0, sof_cyc = 0, eof_cyc = 0;
  int vld_pct = 100, rdy_pct = 100, rdy_mode = 0;
  hw_t exp_q[$];
  logic [31:0] src[$], nxt[$], wq[$];
  logic [2:0] exp_cnt = '0;
  logic ovr_exp = 1'b0, ovr_next = 1'b0, pend = 1'b0, pend_ab = 1'b0, in_fire = 1'b0;
  logic stall_prev = 1'b0;
  hw_t held;
`ifdef FRAME_TX_CHECKSUM_EN
  localparam int CKX = 2;
`else
  localparam int CKX = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // expected frame: each word low half then high half, optional checksum trailer carrying eof
  task automatic build_frame(input logic ab);
    logic [31:0] ck;
    ck = '0;
    if (ab) exp_q.delete();
    else chk("leftover_halfwords", 32'(exp_q.size()), 0);
    src = nxt;
    accepted = 0;
    n_pop = 0;
    foreach (nxt[i]) begin
      exp_q.push_back('{nxt[i][15:0], i == 0, 1'b0});
      exp_q.push_back('{nxt[i][31:16], 1'b0, CKX == 0 && i == nxt.size() - 1});
      ck += nxt[i];
    end
    if (CKX != 0 && nxt.size() != 0) begin
      exp_q.push_back('{ck[15:0], 1'b0, 1'b0});
      exp_q.push_back('{ck[31:16], 1'b0, 1'b1});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    in_fire = i_in_vld && o_in_rdy;
    if (in_fire) accepted++;
    @(posedge clk);
    #1;
    if (in_fire && src.size() != 0) void'(src.pop_front());
    i_sync = 1'b0;
    if (pend) begin
      build_frame(pend_ab);
      pend = 1'b0;
    end
    ovr_exp = ovr_next;
    ovr_next = 1'b0;
    i_in_vld = src.size() != 0 && ((i_in_vld && !in_fire) || $urandom_range(99) < vld_pct);
    i_in_data = src.size() != 0 ? src[0] : $urandom;
    i_tx_rdy = rdy_mode == 1 ? (cyc % 3 == 0) : ($urandom_range(99) < rdy_pct);
  endtask

  task automatic start_frame(input int h, input int p, input logic ab);
    nxt.delete();
    for (int i = 0; i < h + p; i++) nxt.push_back(wq.size() != 0 ? wq.pop_front() : $urandom);
    i_sync = 1'b1;
    i_header_size = 16'(h);
    i_payload_len = 16'(p);
    pend = 1'b1;
    pend_ab = ab;
    ovr_next = ab;
    cycle();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < budget) begin
      cycle();
      k++;
    end
    chk("frame_done_in_budget", 32'(k < budget), 1);
  endtask

  task automatic load_plan();
    wq = '{32'hEC534F4D, 32'h00000001, 32'h00000010, 32'h00000020, 32'h11111111, 32'h22222222};
  endtask

  always @(negedge clk) begin
    if (!rst_n) stall_prev = 1'b0;
    else begin
      chk("overrun", 32'(o_overrun), 32'(ovr_exp));
      chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      if (stall_prev && o_tx_vld) chk("hold_while_stalled", 32'({o_tx_data, o_tx_sof, o_tx_eof}), 32'(held));
      if (o_tx_vld && i_tx_rdy) begin
        chk("halfword_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          hw_t e;
          e = exp_q.pop_front();
          chk("halfword", 32'({o_tx_data, o_tx_sof, o_tx_eof}), 32'(e));
          n_pop++;
          if (e.sof) sof_cyc = cyc;
          if (e.eof) begin
            eof_cyc = cyc;
            exp_cnt = exp_cnt + 1'b1;
          end
        end
      end
      stall_prev = o_tx_vld && !i_tx_rdy && !i_sync;
      held = '{o_tx_data, o_tx_sof, o_tx_eof};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, h, p;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({o_in_rdy, o_tx_data, o_tx_vld, o_tx_sof, o_tx_eof, o_busy, o_frame_cnt, o_overrun}), 0);
    rst_n = 1'b1;
    cycle();
    // reference frame, no backpressure, full throughput
    load_plan();
    start_frame(4, 2, 1'b0);
    wait_idle(200);
    chk("throughput_span", 32'(eof_cyc - sof_cyc), 32'(2 * 6 - 1 + CKX));
    chk("cnt_after_first", 32'(o_frame_cnt), 1);
    // same frame under 1-on/2-off host ready
    rdy_mode = 1;
    load_plan();
    start_frame(4, 2, 1'b0);
    wait_idle(400);
    rdy_mode = 0;
    // overrun after three accepted words
    start_frame(4, 8, 1'b0);
    k = 0;
    while (accepted < 3 && k < 100) begin
      cycle();
      k++;
    end
    chk("three_words_accepted", 32'(accepted >= 3), 1);
    start_frame(2, 3, 1'b1);
    chk("vld_after_overrun_sync", 32'(o_tx_vld), 0);
    chk("busy_after_overrun_sync", 32'(o_busy), 1);
    wait_idle(300);
    // zero-length sync from idle is ignored
    start_frame(0, 0, 1'b0);
    repeat (3) begin
      chk("zero_sync_idle", 32'({o_busy, o_tx_vld, o_in_rdy}), 0);
      cycle();
    end
    // zero-length sync while busy abandons to idle
    start_frame(3, 1, 1'b0);
    repeat (4) cycle();
    start_frame(0, 0, 1'b1);
    chk("zero_sync_busy_idle", 32'({o_busy, o_tx_vld}), 0);
    wait_idle(50);
    // header only frame
    start_frame(4, 0, 1'b0);
    wait_idle(200);
    // sync coincident with eof handshake
    start_frame(1, 1, 1'b0);
    k = 0;
    while (!(o_tx_vld && o_tx_eof && i_tx_rdy) && k < 100) begin
      cycle();
      k++;
    end
    chk("eof_reached", 32'(k < 100), 1);
    start_frame(2, 2, 1'b0);
    wait_idle(200);
    // random frames with random flow control
    for (int f = 0; f < 10; f++) begin
      vld_pct = $urandom_range(100, 50);
      rdy_pct = $urandom_range(100, 30);
      h = $urandom_range(4);
      p = $urandom_range(4);
      if (h + p == 0) p = 1;
      start_frame(h, p, 1'b0);
      wait_idle(600);
    end
    vld_pct = 100;
    rdy_pct = 100;
    // asynchronous reset while emitting a high half
    start_frame(2, 3, 1'b0);
    k = 0;
    while (!(o_tx_vld && n_pop % 2 == 1) && k < 100) begin
      cycle();
      k++;
    end
    chk("reached_high_half", 32'(o_tx_vld && n_pop % 2 == 1), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({o_in_rdy, o_tx_data, o_tx_vld, o_tx_sof, o_tx_eof, o_busy, o_frame_cnt, o_overrun}), 0);
    exp_q.delete();
    src.delete();
    exp_cnt = '0;
    ovr_next = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    start_frame(1, 2, 1'b0);
    wait_idle(200);
    chk("cnt_after_reset", 32'(o_frame_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
